hdmi_cfg_seq: RTL and testbench

Sequencer that configures the board's ADV7513 HDMI transmitter after reset or hot-plug. It walks a fixed table of (register, value) pairs and issues each entry as a byte-level I2C write through a command/response handshake to the I2C byte master. It retries NACKed writes and reports done/error status for debug display on the seven-segment LEDs. It sits between the top-level chip interface and the I2C bus driver.

---
 rtl/hdmi_cfg_pkg.sv | 21 ++
 rtl/hdmi_cfg_seq_rom.sv | 32 +++
 rtl/hdmi_cfg_seq.sv | 158 +++++++++++++++
 tb/tb_hdmi_cfg_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_cfg_pkg.sv
// hdmi_cfg_pkg: shared types and constants for the ADV7513 configuration sequencer.
package hdmi_cfg_pkg;

    localparam logic [7:0] ADV7513_ADDR = 8'h72;

    typedef enum logic [1:0] {
        CMD_START_WR = 2'd0,
        CMD_WR       = 2'd1,
        CMD_STOP     = 2'd2
    } cmd_op_t;

    typedef enum logic [3:0] {
        IDLE, PWRUP, DEV, REG, DATA, STOP, NEXT, BACKOFF, DONE, FAIL
    } state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] val;
    } cfg_entry_t;

endpackage

// File: rtl/hdmi_cfg_seq_rom.sv
// adv7513_init_rom: fixed ADV7513 init table, index to (register, value).
module adv7513_init_rom
    import hdmi_cfg_pkg::*;
(
    input  logic [3:0] idx_i,
    output cfg_entry_t entry_o
);

    always_comb begin
        entry_o = {8'h00, 8'h00};
        case (idx_i)
            4'd0:  entry_o = {8'h41, 8'h10};
            4'd1:  entry_o = {8'h98, 8'h03};
            4'd2:  entry_o = {8'h9A, 8'hE0};
            4'd3:  entry_o = {8'h9C, 8'h30};
            4'd4:  entry_o = {8'h9D, 8'h61};
            4'd5:  entry_o = {8'hA2, 8'hA4};
            4'd6:  entry_o = {8'hA3, 8'hA4};
            4'd7:  entry_o = {8'hE0, 8'hD0};
            4'd8:  entry_o = {8'hF9, 8'h00};
            4'd9:  entry_o = {8'h15, 8'h00};
            4'd10: entry_o = {8'h16, 8'h30};
            4'd11: entry_o = {8'h18, 8'h46};
            4'd12: entry_o = {8'hAF, 8'h04};
            4'd13: entry_o = {8'h55, 8'h00};
            4'd14: entry_o = {8'h56, 8'h08};
            4'd15: entry_o = {8'hD6, 8'hC0};
            default: entry_o = {8'h00, 8'h00};
        endcase
    end

endmodule

// File: rtl/hdmi_cfg_seq.sv
// hdmi_cfg_seq: walks the ADV7513 init table as byte-level I2C writes,
// retrying NACKed entries and reporting done/error status.
module hdmi_cfg_seq
    import hdmi_cfg_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR       = ADV7513_ADDR,
    parameter int          NUM_REGS       = 16,
    parameter int          MAX_RETRY      = 3,
    parameter logic [19:0] PWRUP_CYCLES   = 20'd200000,
    parameter logic [15:0] BACKOFF_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hpd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_data,
    input  logic       rsp_valid,
    input  logic       rsp_ack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] idx,
    output logic [1:0] retry_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
    localparam logic [1:0] MAX_R    = 2'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic        nack_q, nack_d;
    logic        abort_q, abort_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  retry_q, retry_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        hpd_s1_q, hpd_s2_q, hpd_p_q;
    cfg_entry_t  entry;

    adv7513_init_rom u_rom (.idx_i(idx_q), .entry_o(entry));

    wire hpd_rise  = hpd_s2_q & ~hpd_p_q;
    wire hpd_fall  = ~hpd_s2_q & hpd_p_q;
    wire trig      = start | hpd_rise;
    wire abort_now = abort_q | hpd_fall;

    // phase_q: 0 = issuing the command, 1 = waiting for its response
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        nack_d  = nack_q;
        abort_d = abort_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        done_d  = done_q;
        error_d = error_q;
        case (state_q)
            IDLE, DONE, FAIL: if (trig) begin
                state_d = PWRUP;
                cnt_d   = PWRUP_CYCLES - 20'd1;
                phase_d = 1'b0;
                nack_d  = 1'b0;
                abort_d = 1'b0;
                idx_d   = '0;
                retry_d = '0;
                done_d  = 1'b0;
                error_d = 1'b0;
            end
            PWRUP: begin
                state_d = hpd_fall ? IDLE : cnt_q == '0 ? DEV : PWRUP;
                cnt_d   = cnt_q - 20'd1;
            end
            DEV, REG, DATA: begin
                abort_d = abort_now;
                if (!phase_q) phase_d = cmd_ready;
                else if (rsp_valid) begin
                    phase_d = 1'b0;
                    nack_d  = !rsp_ack;
                    state_d = (abort_now || !rsp_ack) ? STOP :
                              state_q == DEV ? REG : state_q == REG ? DATA : STOP;
                end
            end
            STOP: begin
                abort_d = abort_now;
                if (!phase_q) phase_d = cmd_ready;
                else if (rsp_valid) begin
                    phase_d = 1'b0;
                    cnt_d   = 20'(BACKOFF_CYCLES) - 20'd1;
                    state_d = abort_now ? IDLE : nack_q ? BACKOFF : NEXT;
                end
            end
            BACKOFF: begin
                cnt_d = cnt_q - 20'd1;
                if (hpd_fall) state_d = IDLE;
                else if (cnt_q == '0) begin
                    state_d = retry_q == MAX_R ? FAIL : DEV;
                    error_d = retry_q == MAX_R;
                    retry_d = retry_q == MAX_R ? retry_q : retry_q + 2'd1;
                    nack_d  = 1'b0;
                end
            end
            NEXT: begin
                retry_d = '0;
                state_d = hpd_fall ? IDLE : idx_q == LAST_IDX ? DONE : DEV;
                done_d  = !hpd_fall && idx_q == LAST_IDX;
                idx_d   = (!hpd_fall && idx_q != LAST_IDX) ? idx_q + 4'd1 : idx_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            nack_q   <= 1'b0;
            abort_q  <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            hpd_s1_q <= 1'b0;
            hpd_s2_q <= 1'b0;
            hpd_p_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            nack_q   <= nack_d;
            abort_q  <= abort_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            done_q   <= done_d;
            error_q  <= error_d;
            hpd_s1_q <= hpd;
            hpd_s2_q <= hpd_s1_q;
            hpd_p_q  <= hpd_s2_q;
        end
    end

    assign cmd_valid = (state_q inside {DEV, REG, DATA, STOP}) && !phase_q;
    assign cmd_op    = state_q == STOP ? CMD_STOP :
                       (state_q == REG || state_q == DATA) ? CMD_WR : CMD_START_WR;
    assign cmd_data  = state_q == DEV ? DEV_ADDR : state_q == REG ? entry.reg_addr :
                       state_q == DATA ? entry.val : 8'h00;
    assign busy      = !(state_q inside {IDLE, DONE, FAIL});
    assign done      = done_q;
    assign error     = error_q;
    assign idx       = idx_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// tb_hdmi_cfg_seq: scoreboard bench; expected I2C commands are queued up front
// and a monitor pops them as the bus model accepts commands from the DUT.
module tb_hdmi_cfg_seq;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hpd = 1'b0;
    logic cmd_ready = 1'b1, rsp_valid = 1'b0, rsp_ack = 1'b1;
    logic cmd_valid, busy, done, error;
    logic [1:0] cmd_op, retry_cnt;
    logic [7:0] cmd_data;
    logic [3:0] idx;

    always #5 clk = ~clk;

    hdmi_cfg_seq #(.PWRUP_CYCLES(20'd10), .BACKOFF_CYCLES(16'd5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hpd(hpd),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .busy(busy), .done(done), .error(error),
        .idx(idx), .retry_cnt(retry_cnt)
    );

    int tests = 0, fails = 0;
    logic [9:0] exp_q[$], acc_q[$];
    logic [9:0] mon_a, mon_e;
    int acc_cnt = 0, nack_mode = 0, stall_left = 0, rsp_wait = 0;
    bit reg3_nacked = 0, stall_armed = 0, delay_armed = 0, d0_seen = 0;
    logic ack_pend = 1'b1;
    logic [15:0] tbl [16] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                              16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'h1846,
                              16'hAF04, 16'h5500, 16'h5608, 16'hD6C0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push_entry(input int i);
        exp_q.push_back({2'd0, 8'h72});
        exp_q.push_back({2'd1, tbl[i][15:8]});
        exp_q.push_back({2'd1, tbl[i][7:0]});
        exp_q.push_back({2'd2, 8'h00});
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) push_entry(i);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 3000);
        chk({name, "_timeout_busy"}, busy, 0);
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        chk({name, "_pending_cmds"}, exp_q.size(), 0);
    endtask

    // Monitor: compare each accepted command against the scoreboard; STOP carries no data
    initial forever begin
        @(posedge clk);
        #1;
        while (acc_q.size() > 0) begin
            mon_a = acc_q.pop_front();
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_cmd: got op %0d data %0h expected none", mon_a[9:8], mon_a[7:0]);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e[9:8] == 2'd2) chk("cmd_stop_op", mon_a[9:8], 2);
                else chk("cmd", mon_a, mon_e);
            end
        end
    end

    // I2C byte-master model driven on the falling edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rsp_valid = 1'b0;
            rsp_wait = 0;
            stall_left = 0;
            cmd_ready = 1'b1;
        end else begin
            rsp_valid = 1'b0;
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    rsp_valid = 1'b1;
                    rsp_ack = ack_pend;
                end
            end
            if (stall_armed && cmd_valid && cmd_op == 2'd1 && cmd_data == 8'h9A) begin
                stall_left = 5;
                stall_armed = 0;
            end else if (stall_left > 0)
                chk("stall_hold", {cmd_valid, cmd_op, cmd_data}, {1'b1, 2'd1, 8'h9A});
            if (stall_left > 0) begin
                cmd_ready = 1'b0;
                stall_left--;
            end else cmd_ready = 1'b1;
            if (cmd_valid && cmd_ready) begin
                acc_q.push_back({cmd_op, cmd_data});
                acc_cnt++;
                ack_pend = 1'b1;
                if (nack_mode == 2 && cmd_op == 2'd0) ack_pend = 1'b0;
                if (nack_mode == 1 && !reg3_nacked && cmd_op == 2'd1 && cmd_data == 8'h9C) begin
                    ack_pend = 1'b0;
                    reg3_nacked = 1;
                end
                rsp_wait = 1;
                if (delay_armed && cmd_op == 2'd1 && cmd_data == 8'hD0) begin
                    rsp_wait = 12;
                    delay_armed = 0;
                    d0_seen = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {cmd_valid, busy, done, error, idx, retry_cnt, cmd_op, cmd_data}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full always-ACK run with a ready stall on WR 9A and an ignored mid-run start
        stall_armed = 1;
        push_range(0, 15);
        acc_cnt = 0;
        pulse_start();
        repeat (60) @(negedge clk);
        chk("busy_mid_run", busy, 1);
        pulse_start();
        wait_idle("full");
        drain("full");
        chk("full_done", done, 1);
        chk("full_busy", busy, 0);
        chk("full_cmd_count", acc_cnt, 64);
        chk("full_idx", idx, 15);
        chk("full_error", error, 0);
        chk("stall_seen", stall_armed, 0);

        // One NACK on the register byte of entry 3
        nack_mode = 1;
        reg3_nacked = 0;
        push_range(0, 2);
        exp_q.push_back({2'd0, 8'h72});
        exp_q.push_back({2'd1, 8'h9C});
        exp_q.push_back({2'd2, 8'h00});
        push_range(3, 15);
        pulse_start();
        n = 0;
        do begin @(negedge clk); n++; end while (retry_cnt == 2'd0 && n < 3000);
        chk("retry_during_resend", retry_cnt, 1);
        chk("retry_idx", idx, 3);
        n = 0;
        do begin @(negedge clk); n++; end while (idx != 4'd4 && n < 3000);
        chk("retry_cleared", retry_cnt, 0);
        wait_idle("nack1");
        drain("nack1");
        chk("nack1_done", done, 1);
        chk("nack1_error", error, 0);

        // Permanent NACK on the device address
        nack_mode = 2;
        repeat (4) begin
            exp_q.push_back({2'd0, 8'h72});
            exp_q.push_back({2'd2, 8'h00});
        end
        pulse_start();
        wait_idle("fail");
        drain("fail");
        chk("fail_error", error, 1);
        chk("fail_done", done, 0);
        chk("fail_idx", idx, 0);
        chk("fail_retry", retry_cnt, 3);
        nack_mode = 0;

        // hpd rise triggers; hpd fall while DATA of entry 7 awaits its response
        delay_armed = 1;
        d0_seen = 0;
        push_range(0, 7);
        @(negedge clk) hpd = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!d0_seen && n < 3000);
        chk("abort_reached_d0", d0_seen, 1);
        hpd = 1'b0;
        wait_idle("abort");
        drain("abort");
        chk("abort_done", done, 0);
        chk("abort_error", error, 0);
        chk("abort_idx", idx, 7);

        // Later hpd rise restarts from entry 0
        push_range(0, 15);
        @(negedge clk) hpd = 1'b1;
        repeat (6) @(negedge clk);
        chk("restart_busy", busy, 1);
        chk("restart_idx", idx, 0);
        wait_idle("restart");
        drain("restart");
        chk("restart_done", done, 1);
        chk("restart_idx_end", idx, 15);

        // Asynchronous reset while the REG command is being issued
        exp_q.push_back({2'd0, 8'h72});
        pulse_start();
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(cmd_valid && cmd_op == 2'd1) && n < 500);
        chk("reg_issue", {cmd_valid, cmd_op, cmd_data}, {1'b1, 2'd1, 8'h41});
        rst_n = 1'b0;
        hpd = 1'b0;
        #1;
        chk("async_reset_outputs", {cmd_valid, busy, done, error, idx, retry_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_reset_idle", busy, 0);
        drain("reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
